// File: rtl/clk_div_pkg.sv
// clk_div_pkg: FSM state encoding and default parameters
// shared by the clk_div_gen divider and its counter.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_RST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWITCH
  } state_e;

endpackage

// File: rtl/clk_div_ctr.sv
// clk_div_ctr: programmable half-period counter with toggle
// output and a one-cycle strobe on each rising output edge.
module clk_div_ctr
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] ratio_i,
  input  logic             load_i,
  input  logic             run_i,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;

  // >= keeps the wrap safe if the ratio ever shrinks under the count
  assign last_o = (cnt_q >= ratio_i - CNT_W'(1));

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    tick_d = 1'b0;
    if (!run_i) begin
      cnt_d = '0;
      div_d = 1'b0;
    end else if (last_o) begin
      cnt_d  = '0;
      div_d  = ~div_q;
      tick_d = ~div_q;
    end else if (load_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      div_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign clk_div_o = div_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: fixed /2 and /4 clocks plus a glitch-free programmable
// divider. Optional edge_cnt output with CLK_DIV_GEN_EDGE_CNT_EN.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             clk50,
  output logic             clk25,
  output logic             clk_div,
  output logic             tick_div,
  output logic             busy
`ifdef CLK_DIV_GEN_EDGE_CNT_EN
  ,
  output logic [15:0]      edge_cnt
`endif
);

  localparam logic [CNT_W-1:0] RATIO_RST =
    (DIV_RST < 1) ? CNT_W'(1) : CNT_W'(DIV_RST);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] req_r;
  logic [1:0]       ph_q, ph_d;
  logic             ack_q, ack_d;
  logic             run, apply, last, load;

  assign req_r = (div_val == '0) ? CNT_W'(1) : div_val;
  assign run   = en && (state_q != IDLE);
  // new ratio only lands as clk_div falls, so no high phase is cut
  assign apply = run && (state_q == SWITCH) && last && clk_div;
  assign load  = apply || ((state_q == IDLE) && div_req);

  always_comb begin
    state_d = state_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    ph_d    = run ? ph_q + 2'd1 : 2'd0;
    unique case (state_q)
      IDLE: begin
        if (div_req) begin
          ratio_d = req_r;
          ack_d   = 1'b1;
        end
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
        end else if (div_req) begin
          pend_d  = req_r;
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          if (apply) begin
            ratio_d = pend_q;
            ack_d   = 1'b1;
            state_d = RUN;
          end
          if (div_req) begin
            pend_d  = req_r;
            state_d = SWITCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ratio_q <= RATIO_RST;
      pend_q  <= RATIO_RST;
      ph_q    <= 2'd0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ratio_q <= ratio_d;
      pend_q  <= pend_d;
      ph_q    <= ph_d;
      ack_q   <= ack_d;
    end
  end

  clk_div_ctr #(
    .CNT_W(CNT_W)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .ratio_i  (ratio_q),
    .load_i   (load),
    .run_i    (run),
    .clk_div_o(clk_div),
    .tick_o   (tick_div),
    .last_o   (last)
  );

  assign clk50   = ph_q[0];
  assign clk25   = ph_q[1];
  assign div_ack = ack_q;
  assign busy    = (state_q == SWITCH);

`ifdef CLK_DIV_GEN_EDGE_CNT_EN
  logic [15:0] edge_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= 16'd0;
    end else if (tick_div && (state_q != IDLE)) begin
      edge_cnt_q <= edge_cnt_q + 16'd1;
    end
  end

  assign edge_cnt = edge_cnt_q;
`endif

endmodule
